// File: rtl/soa_rr_arbiter.sv
// soa_rr_arbiter: two-requester round-robin front end for the shared SOA_5
// set-one log adder of the IALM_SL multiplier array. The granted operand
// pair is summed and captured in a one-entry result register, which also
// carries the winner's source index and tag. The log operand width W is
// fixed at 15 for M=5, and the SOA bit positions below assume that width.
module soa_rr_arbiter #(
  parameter int TW = 4,
  parameter int W  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [W-1:0]  in0_tloga,
  input  logic [W-1:0]  in0_tlogb,
  input  logic [TW-1:0] in0_tag,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [W-1:0]  in1_tloga,
  input  logic [W-1:0]  in1_tlogb,
  input  logic [TW-1:0] in1_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [19:0]   out_sumlog,
  output logic          out_cin_est,
  output logic          out_src,
  output logic [TW-1:0] out_tag
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t   slot_state;
  logic          rr_ptr;
  logic          slot_free;
  logic          grant_any;
  logic          grant_idx;
  logic          accept;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [TW-1:0] sel_tag;
  logic          soa_cin;
  logic [W-1:0]  half_a;
  logic [W-1:0]  half_b;
  logic [W-1:0]  soa_sum;
  logic [19:0]   soa_sumlog;
  logic          soa_cin_est;

  assign out_valid = (slot_state == FULL);

  // Pick a winner: a lone requester always wins, a tie goes to rr_ptr; the
  // slot can take a new result when empty or being drained this cycle.
  always_comb begin
    grant_any = in0_valid || in1_valid;
    grant_idx = (in0_valid && in1_valid) ? rr_ptr : in1_valid;
    slot_free = !out_valid || out_ready;
    accept    = grant_any && slot_free && !clr;
    in0_ready = accept && !grant_idx;
    in1_ready = accept && grant_idx;
  end

  // Steer the winning operand pair through the set-one adder. The carry
  // into bit 10 is recovered from the sum bit and the two operand bits.
  always_comb begin
    sel_a       = grant_idx ? in1_tloga : in0_tloga;
    sel_b       = grant_idx ? in1_tlogb : in0_tlogb;
    sel_tag     = grant_idx ? in1_tag   : in0_tag;
    soa_cin     = sel_a[0] & sel_b[0];
    half_a      = {1'b0, sel_a[W-1:1]};
    half_b      = {1'b0, sel_b[W-1:1]};
    soa_sum     = half_a + half_b + {{(W-1){1'b0}}, soa_cin};
    soa_cin_est = soa_sum[10] ^ half_a[10] ^ half_b[10];
    soa_sumlog  = {soa_sum, 5'b11111};
  end

  // Result slot and round-robin pointer: clear wins over accept, an accept
  // loads new data (even while draining), otherwise a drain empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_state  <= EMPTY;
      rr_ptr      <= 1'b0;
      out_sumlog  <= '0;
      out_cin_est <= 1'b0;
      out_src     <= 1'b0;
      out_tag     <= '0;
    end else if (clr) begin
      slot_state <= EMPTY;
      rr_ptr     <= 1'b0;
    end else if (accept) begin
      slot_state  <= FULL;
      rr_ptr      <= !grant_idx;
      out_sumlog  <= soa_sumlog;
      out_cin_est <= soa_cin_est;
      out_src     <= grant_idx;
      out_tag     <= sel_tag;
    end else if (out_ready) begin
      slot_state <= EMPTY;
    end
  end

endmodule
